sr_bank_ctrl: RTL and testbench

Round-robin controller that shares a bank of `NFF` SR flip-flops among `NREQ` requesters. Each requester asks to set or clear one flop by index. The controller grants one request at a time and drives the selected flop's `s` or `r` input for exactly one cycle. It never drives the illegal `s=r=1` combination. Optionally it reads back `q` to confirm the update. The block sits between software/FSM agents and the SR flag bank.

---
 rtl/sr_bank_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sr_bank_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl
// Round-robin controller sharing a bank of NFF SR flip-flops among NREQ
// requesters. One request is granted at a time, and the selected flop gets a
// single-cycle set or reset pulse. The block never drives s=r=1.
//
// Optional feature macro: SR_BANK_CTRL_READBACK_EN
//   defined   : a CHECK state compares q_in against the expected value.
//               Request-to-done latency is 3 cycles.
//   undefined : DRIVE returns straight to IDLE and q_in is ignored.
//               Latency is 2 cycles, and err flags only an out-of-range index.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   req    : per-requester request
//   op     : per-requester operation, 1 = set, 0 = clear
//   idx    : per-requester flop index, requester k at [k*IDXW +: IDXW]
//   gnt    : one-hot grant pulse (during DRIVE)
//   done   : one-hot completion pulse (first IDLE cycle after the operation)
//   err    : error flag, pulses with done
//   s_out  : set lines to the flop bank
//   r_out  : reset lines to the flop bank
//   q_in   : q readback from the flop bank
//   busy   : high while not IDLE
module sr_bank_ctrl #(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IDXW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [NFF-1:0]       s_out,
    output logic [NFF-1:0]       r_out,
    input  logic [NFF-1:0]       q_in,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     ptr_r, ptr_s;
    logic [PW-1:0]     win_r, win_s;
    logic              op_r, op_s;
    logic [IDXW-1:0]   idx_r, idx_s;
    logic [PW-1:0]     arb_s;
    logic              found_s;
    logic [IDXW-1:0]   req_idx_s;
    logic              in_range_s;
    logic [NREQ-1:0]   gnt_s, done_s;
    logic              err_s, busy_s;
    logic [NFF-1:0]    s_s, r_s;

    // One-hot requester vector for requester number sel.
    function automatic logic [NREQ-1:0] req_onehot(input logic [PW-1:0] sel);
        logic [NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == PW'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // One-hot flop select. An index of NFF or above yields all zeros, so an
    // out-of-range request can never reach the bank.
    function automatic logic [NFF-1:0] flop_sel(input logic [IDXW-1:0] i_idx);
        logic [NFF-1:0] v;
        v = '0;
        for (int i = 0; i < NFF; i++) begin
            if (i_idx == IDXW'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Round-robin search starting at the pointer and wrapping modulo NREQ.
    always_comb begin
        logic [PW-1:0] cand;
        found_s = 1'b0;
        arb_s   = ptr_r;
        cand    = ptr_r;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr_r) + i) % NREQ);
            if (!found_s && req[cand]) begin
                found_s = 1'b1;
                arb_s   = cand;
            end else begin
                found_s = found_s;
            end
        end
        req_idx_s = idx[int'(arb_s)*IDXW +: IDXW];
    end

    assign in_range_s = |flop_sel(idx_r);

`ifdef SR_BANK_CTRL_READBACK_EN
    logic q_bit_s;
    assign q_bit_s = |(q_in & flop_sel(idx_r));
`else
    logic unused_s;
    assign unused_s = ^{q_in, op_r};
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        win_s   = win_r;
        op_s    = op_r;
        idx_s   = idx_r;
        gnt_s   = '0;
        done_s  = '0;
        err_s   = 1'b0;
        s_s     = '0;
        r_s     = '0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    win_s = arb_s;
                    op_s  = op[arb_s];
                    idx_s = req_idx_s;
                    ptr_s = PW'((int'(arb_s) + 1) % NREQ);
                    gnt_s = req_onehot(arb_s);
                    // The pulse is registered on the grant edge, so it is
                    // visible during DRIVE together with gnt.
                    if (op[arb_s]) begin
                        s_s = flop_sel(req_idx_s);
                    end else begin
                        r_s = flop_sel(req_idx_s);
                    end
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
`ifdef SR_BANK_CTRL_READBACK_EN
                state_s = CHECK;
`else
                state_s = IDLE;
                done_s  = req_onehot(win_r);
                err_s   = !in_range_s;
`endif
            end
            CHECK: begin
                state_s = IDLE;
`ifdef SR_BANK_CTRL_READBACK_EN
                done_s  = req_onehot(win_r);
                err_s   = !in_range_s || (q_bit_s != op_r);
`endif
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, transaction context and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            win_r   <= '0;
            op_r    <= 1'b0;
            idx_r   <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            s_out   <= '0;
            r_out   <= '0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            win_r   <= win_s;
            op_r    <= op_s;
            idx_r   <= idx_s;
            gnt     <= gnt_s;
            done    <= done_s;
            err     <= err_s;
            s_out   <= s_s;
            r_out   <= r_s;
            busy    <= busy_s;
        end
    end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed testbench for sr_bank_ctrl (NREQ=4, NFF=6, IDXW=3).
// Models the SR flop bank, and can force individual q bits to 1 or 0.
module tb_sr_bank_ctrl;

    localparam int NREQ = 4;
    localparam int NFF  = 6;
    localparam int IDXW = 3;
`ifdef SR_BANK_CTRL_READBACK_EN
    localparam int LAT = 3;
    localparam bit RB  = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit RB  = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      op = '0;
    logic [NREQ*IDXW-1:0] idx = '0;
    logic [NREQ-1:0]      gnt, done;
    logic                 err, busy;
    logic [NFF-1:0]       s_out, r_out, q_in;
    logic [NFF-1:0]       q_bank = '0;
    logic [NFF-1:0]       force_one = '0;
    logic [NFF-1:0]       force_zero = '0;

    int n_vec = 0;
    int n_bad = 0;

    sr_bank_ctrl #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op    (op),
        .idx   (idx),
        .gnt   (gnt),
        .done  (done),
        .err   (err),
        .s_out (s_out),
        .r_out (r_out),
        .q_in  (q_in),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // SR flop bank model.
    always @(posedge clk) q_bank <= (q_bank | s_out) & ~r_out;
    assign q_in = (q_bank | force_one) & ~force_zero;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        idx   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // After the grant cycle: LAT-2 quiet cycles, then done/err.
    task automatic finish_op(input string tag, input logic [3:0] exp_done, input logic exp_err);
        for (int k = 0; k < LAT - 2; k++) begin
            tick();
            chk({tag, "_quiet_sr"}, 32'(s_out | r_out), 32'd0);
            chk({tag, "_quiet_done"}, 32'(done), 32'd0);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sr", 32'({s_out, r_out}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single set: requester 0, set, idx 5
        req = 4'b0001; op = 4'b0001; idx[0 +: IDXW] = 3'd5;
        tick();
        chk("set_gnt", 32'(gnt), 32'h1);
        chk("set_s", 32'(s_out), 32'h20);
        chk("set_r", 32'(r_out), 32'h0);
        chk("set_busy", 32'(busy), 32'd1);
        req = '0;
        finish_op("set", 4'b0001, 1'b0);
        chk("set_after_gnt", 32'(gnt), 32'd0);

        // Fairness: all four requesting, each setting its own flop
        do_reset();
        req = 4'b1111; op = 4'b1111;
        for (int k = 0; k < NREQ; k++) idx[k*IDXW +: IDXW] = IDXW'(k);
        for (int c = 1; c <= 5 * LAT; c++) begin
            logic [31:0] e;
            tick();
            e = ((c - 1) % LAT == 0) ? 32'(1 << (((c - 1) / LAT) % 4)) : 32'd0;
            chk($sformatf("fair_gnt_c%0d", c), 32'(gnt), e);
            chk($sformatf("fair_s_c%0d", c), 32'(s_out), e);
            chk($sformatf("fair_sr_c%0d", c), 32'(s_out & r_out), 32'd0);
        end
        req = '0;

        // Readback mismatch: clear idx 2 while q[2] is stuck at 1
        do_reset();
        force_one = 6'b000100;
        req = 4'b0001; op = 4'b0000; idx[0 +: IDXW] = 3'd2;
        tick();
        chk("mis_gnt", 32'(gnt), 32'h1);
        chk("mis_r", 32'(r_out), 32'h04);
        chk("mis_s", 32'(s_out), 32'h0);
        req = '0;
        finish_op("mis", 4'b0001, RB);
        force_one = '0;

        // Out-of-range index 7 on requester 1
        do_reset();
        req = 4'b0010; op = 4'b0010; idx[1*IDXW +: IDXW] = 3'd7;
        tick();
        chk("oor_gnt", 32'(gnt), 32'h2);
        chk("oor_sr", 32'(s_out | r_out), 32'd0);
        req = '0;
        finish_op("oor", 4'b0010, 1'b1);

        // Reset in the DRIVE cycle
        do_reset();
        req = 4'b0100; op = 4'b0100; idx[2*IDXW +: IDXW] = 3'd3;
        tick();
        chk("mid_gnt", 32'(gnt), 32'h4);
        chk("mid_s", 32'(s_out), 32'h08);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_outs", 32'({gnt, done, err, s_out, r_out}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        req = '0;
        for (int k = 0; k < LAT; k++) begin
            tick();
            chk("mid_no_done", 32'({done, err}), 32'd0);
        end
        req = 4'b1111;
        tick();
        chk("mid_ptr_restart", 32'(gnt), 32'h1);
        req = '0;

`ifndef SR_BANK_CTRL_READBACK_EN
        // q_in held at 0 produces no err
        do_reset();
        force_zero = '1;
        req = 4'b0001; op = 4'b0001; idx[0 +: IDXW] = 3'd5;
        tick();
        chk("nrb_s", 32'(s_out), 32'h20);
        req = '0;
        finish_op("nrb", 4'b0001, 1'b0);
        force_zero = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
